// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids, downstream request payload.
// Feature macro: MEM_ARB_RR_EN (round-robin arbitration instead of fixed priority with starvation limit).
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } mem_req_t;

  localparam logic [MASK_W-1:0] FETCH_MASK = {MASK_W{1'b1}};

  // Requester that gets priority after `id` has been served.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// Default: data wins unless fetch is waiting and the starvation count reached STARVE_LIMIT.
// MEM_ARB_RR_EN defined: on contention the requester named by i_rr_prio wins.
// Ports: i_imem_req/i_dmem_req requests; i_starve_cnt or i_rr_prio arbitration state;
//        o_gnt_valid any request present; o_gnt_id winning requester.
module mem_arb_pick
  import mem_arb_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
  parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
  input  logic             i_imem_req,
  input  logic             i_dmem_req,
`ifdef MEM_ARB_RR_EN
  input  req_id_e          i_rr_prio,
`else
  input  logic [CNT_W-1:0] i_starve_cnt,
`endif
  output logic             o_gnt_valid,
  output req_id_e          o_gnt_id
);

  // Fetch wins when alone, or on contention when the arbitration state favours it.
  always_comb begin
    o_gnt_valid = i_imem_req | i_dmem_req;
    o_gnt_id    = REQ_D;
`ifdef MEM_ARB_RR_EN
    if (i_imem_req && (!i_dmem_req || (i_rr_prio == REQ_I))) begin
      o_gnt_id = REQ_I;
    end
`else
    if (i_imem_req && (!i_dmem_req || (i_starve_cnt == CNT_W'(STARVE_LIMIT)))) begin
      o_gnt_id = REQ_I;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data requesters,
// one transaction outstanding at a time.
// Feature macro: MEM_ARB_RR_EN selects round-robin; otherwise fixed data priority with a
// STARVE_LIMIT-bounded starvation counter for fetch.
// Ports: i_imem_* / o_imem_* fetch port; i_dmem_* / o_dmem_* data port;
//        o_mem_* / i_mem_* downstream port. Handshake = o_mem_req & i_mem_ready.
// All outputs are combinational from state and inputs and forced to zero while i_rst_n is low.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_imem_req,
  input  logic [ADDR_W-1:0] i_imem_addr,
  output logic              o_imem_ready,
  output logic              o_imem_rvalid,
  output logic [DATA_W-1:0] o_imem_rdata,
  input  logic              i_dmem_req,
  input  logic [ADDR_W-1:0] i_dmem_addr,
  input  logic              i_dmem_wen,
  input  logic [DATA_W-1:0] i_dmem_wdata,
  input  logic [MASK_W-1:0] i_dmem_mask,
  output logic              o_dmem_ready,
  output logic              o_dmem_rvalid,
  output logic [DATA_W-1:0] o_dmem_rdata,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [MASK_W-1:0] o_mem_mask,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  state_e   r_state;
  state_e   w_next;
  logic     w_gnt_valid;
  req_id_e  w_gnt_id;
  logic     w_hs;
  mem_req_t w_mem;

`ifdef MEM_ARB_RR_EN
  req_id_e  r_rr_prio;

  mem_arb_pick u_pick (
    .i_imem_req  (i_imem_req),
    .i_dmem_req  (i_dmem_req),
    .i_rr_prio   (r_rr_prio),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );
`else
  logic [CNT_W-1:0] r_starve_cnt;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_imem_req   (i_imem_req),
    .i_dmem_req   (i_dmem_req),
    .i_starve_cnt (r_starve_cnt),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_id     (w_gnt_id)
  );
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Priority passes to the other requester after every accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_prio <= REQ_I;
    end else if (w_hs) begin
      r_rr_prio <= other_req(w_gnt_id);
    end
  end
`else
  // Counts data grants taken while fetch was waiting; any fetch grant or uncontended data grant clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_hs) begin
      if ((w_gnt_id == REQ_D) && i_imem_req) begin
        if (r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
          r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end
`endif

  // Next state, downstream request mux and response routing.
  always_comb begin
    w_next        = r_state;
    w_mem         = '0;
    w_hs          = 1'b0;
    o_mem_req     = 1'b0;
    o_imem_ready  = 1'b0;
    o_dmem_ready  = 1'b0;
    o_imem_rvalid = 1'b0;
    o_dmem_rvalid = 1'b0;
    o_imem_rdata  = '0;
    o_dmem_rdata  = '0;
    if (i_rst_n) begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            o_mem_req = 1'b1;
            w_hs      = i_mem_ready;
            if (w_gnt_id == REQ_I) begin
              w_mem.addr = i_imem_addr;
              w_mem.mask = FETCH_MASK;
              if (i_mem_ready) begin
                o_imem_ready = 1'b1;
                w_next       = ST_WAIT_I;
              end
            end else begin
              w_mem.addr  = i_dmem_addr;
              w_mem.wen   = i_dmem_wen;
              w_mem.wdata = i_dmem_wdata;
              w_mem.mask  = i_dmem_mask;
              if (i_mem_ready) begin
                o_dmem_ready = 1'b1;
                w_next       = ST_WAIT_D;
              end
            end
          end
        end
        ST_WAIT_I: begin
          if (i_mem_rvalid) begin
            o_imem_rvalid = 1'b1;
            o_imem_rdata  = i_mem_rdata;
            w_next        = ST_IDLE;
          end
        end
        ST_WAIT_D: begin
          if (i_mem_rvalid) begin
            o_dmem_rvalid = 1'b1;
            o_dmem_rdata  = i_mem_rdata;
            w_next        = ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign o_mem_addr  = w_mem.addr;
  assign o_mem_wen   = w_mem.wen;
  assign o_mem_wdata = w_mem.wdata;
  assign o_mem_mask  = w_mem.mask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_LIMIT=2).
// Build with MEM_ARB_RR_EN defined to check the round-robin grant order instead.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_imem_req    (imem_req),
    .i_imem_addr   (imem_addr),
    .o_imem_ready  (imem_ready),
    .o_imem_rvalid (imem_rvalid),
    .o_imem_rdata  (imem_rdata),
    .i_dmem_req    (dmem_req),
    .i_dmem_addr   (dmem_addr),
    .i_dmem_wen    (dmem_wen),
    .i_dmem_wdata  (dmem_wdata),
    .i_dmem_mask   (dmem_mask),
    .o_dmem_ready  (dmem_ready),
    .o_dmem_rvalid (dmem_rvalid),
    .o_dmem_rdata  (dmem_rdata),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .o_mem_wen     (mem_wen),
    .o_mem_wdata   (mem_wdata),
    .o_mem_mask    (mem_mask),
    .i_mem_ready   (mem_ready),
    .i_mem_rvalid  (mem_rvalid),
    .i_mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_g [6];

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_g = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
`endif
    rst_n = 1'b0; imem_req = 1'b1; imem_addr = 32'h0;
    dmem_req = 1'b1; dmem_addr = 32'h0; dmem_wen = 1'b0; dmem_wdata = 32'h0; dmem_mask = 4'h0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    // Reset: outputs zero even with requests pending.
    @(negedge clk); #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_readys", 32'({imem_ready, dmem_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_req = 1'b0; dmem_req = 1'b0;

    // Single fetch, response three cycles after handshake.
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h100; #1;
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_mask", 32'(mem_mask), 32'hF);
    chk("f_mem_wen", 32'(mem_wen), 32'd0);
    chk("f_readys", 32'({imem_ready, dmem_ready}), 32'b10);
    @(negedge clk);
    imem_req = 1'b0; #1;
    chk("f_wait_req", 32'(mem_req), 32'd0);
    chk("f_wait_ready", 32'(imem_ready), 32'd0);
    chk("f_wait_rvalid", 32'(imem_rvalid), 32'd0);
    @(negedge clk); #1;
    chk("f_wait2_rvalid", 32'(imem_rvalid), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk("f_rvalid", 32'({imem_rvalid, dmem_rvalid}), 32'b10);
    chk("f_rdata", imem_rdata, 32'hDEADBEEF);
    chk("f_dmem_rdata", dmem_rdata, 32'h0);

    // Spurious response while idle.
    @(negedge clk); #1;
    chk("spur_rvalid", 32'({imem_rvalid, dmem_rvalid}), 32'd0);
    chk("spur_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;

    // Contention: data write wins, fetch served after the ack.
    @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h104;
    dmem_req = 1'b1; dmem_addr = 32'h2000; dmem_wen = 1'b1; dmem_wdata = 32'h11223344; dmem_mask = 4'b1100; #1;
    chk("c_readys", 32'({imem_ready, dmem_ready}), 32'b01);
    chk("c_mem_addr", mem_addr, 32'h2000);
    chk("c_mem_wen", 32'(mem_wen), 32'd1);
    chk("c_mem_mask", 32'(mem_mask), 32'b1100);
    chk("c_mem_wdata", mem_wdata, 32'h11223344);
    @(negedge clk);
    dmem_req = 1'b0; dmem_wen = 1'b0; #1;
    chk("c_waitd_req", 32'(mem_req), 32'd0);
    chk("c_waitd_iready", 32'(imem_ready), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h0; #1;
    chk("c_ack", 32'({imem_rvalid, dmem_rvalid}), 32'b01);
    @(negedge clk);
    mem_rvalid = 1'b0; #1;
    chk("c_i_readys", 32'({imem_ready, dmem_ready}), 32'b10);
    chk("c_i_addr", mem_addr, 32'h104);
    @(negedge clk);
    imem_req = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    chk("c_i_rvalid", 32'({imem_rvalid, dmem_rvalid}), 32'b10);
    chk("c_i_rdata", imem_rdata, 32'hCAFEF00D);
    @(negedge clk);
    mem_rvalid = 1'b0;

    // Downstream stalls five cycles: request held, no ready pulse.
    mem_ready = 1'b0; dmem_req = 1'b1; dmem_addr = 32'h3000; dmem_mask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_addr", mem_addr, 32'h3000);
      chk("stall_ready", 32'(dmem_ready), 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    chk("stall_release", 32'(dmem_ready), 32'd1);
    @(negedge clk);
    dmem_req = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D; #1;
    chk("stall_rdata", dmem_rdata, 32'h0BADF00D);
    @(negedge clk);
    mem_rvalid = 1'b0;

    // Reset while waiting on a data response.
    dmem_req = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h4000; #1;
    chk("r_hs", 32'(dmem_ready), 32'd1);
    @(negedge clk);
    dmem_req = 1'b0; dmem_wen = 1'b0; imem_req = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
    chk("r_pre_rvalid", 32'(dmem_rvalid), 32'd1);
    rst_n = 1'b0; #1;
    chk("r_rvalid", 32'({imem_rvalid, dmem_rvalid}), 32'd0);
    chk("r_rdata", dmem_rdata, 32'h0);
    chk("r_mem_req", 32'(mem_req), 32'd0);
    chk("r_readys", 32'({imem_ready, dmem_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_req = 1'b0; #1;
    chk("r_spur_rvalid", 32'({imem_rvalid, dmem_rvalid}), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;

    // Both requesters held high: grant order from reset state.
    imem_req = 1'b1; imem_addr = 32'h200;
    dmem_req = 1'b1; dmem_addr = 32'h400; dmem_wen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_rvalid = 1'b0; #1;
      chk($sformatf("grant%0d", i), 32'({imem_ready, dmem_ready}), 32'(exp_g[i]));
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'(i); #1;
      chk($sformatf("resp%0d", i), 32'({imem_rvalid, dmem_rvalid}), 32'(exp_g[i]));
      @(negedge clk);
    end
    mem_rvalid = 1'b0; imem_req = 1'b0; dmem_req = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
